gene_line_stream_ctrl: RTL and testbench
========================================

# gene_line_stream_ctrl

Sequencer for the 100-base line decompressor. It accepts one packed 2-bit-per-base gene line over a valid/ready handshake and presents it from a register to the combinational line decompressor. It then captures the 800-bit character output and streams it as 32-bit (4-character) beats with byte-keep and last flags. It sits between the compressed-line fetch logic and the character output path.

## Interface
- `LINE_BASES`, 100: bases per full line. Fixed by the decompressor width; not to be overridden.
- `CNT_W`, 16: width of the completed-line counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  compressed line offered.
- `in_ready`  out  1  controller can accept a line.
- `in_data`  in  200  packed line; base i in bits [2i+1:2i].
- `in_len`  in  7  valid bases in the line, 1..100.
- `dec_in`  out  200  to decompressor `In`; driven only from the line register.
- `dec_out`  in  800  from decompressor `Out`; byte j is the character for base j.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  32  characters; byte k (bits [8k+7:8k]) is character 4*beat+k.
- `out_keep`  out  4  byte-valid mask for `out_data`.
- `out_last`  out  1  final beat of the line.
- `len_err`  out  1  one-cycle pulse when an out-of-range `in_len` was clamped.
- `busy`  out  1  high in any state other than IDLE.
- `line_cnt`  out  CNT_W  lines fully streamed; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, DECODE, STREAM.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: line_reg<=`in_data`, len_reg<=effective length, go to DECODE.
- Effective length: `in_len` if 1..100. Otherwise (0 or 101..127) use 100 and pulse `len_err` in the cycle after the accepting edge.
- DECODE: one cycle. out_buf<=`dec_out` (combinational from line_reg), beat<=0, beats<=(len_reg+3)>>2, go to STREAM.
- STREAM:
  - `out_valid`=1; `out_data`=out_buf[32*beat+:32].
  - `out_last`=(beat==beats-1).
  - On `out_ready` with not last: beat<=beat+1.
  - On `out_ready` with last: `line_cnt`<=`line_cnt`+1, go to IDLE.
- `out_keep`:
  - 4'b1111 on all beats except the last.
  - Last beat, with r=len_reg[1:0]: r==0 gives 4'b1111; r==1 gives 4'b0001; r==2 gives 4'b0011; r==3 gives 4'b0111.
- Bytes not covered by `out_keep` carry whatever the decompressor produced. Downstream ignores them.
- `in_ready` is 0 in DECODE and STREAM. A new line is not accepted during the last-beat cycle.
- `dec_in` holds line_reg from the end of one accept until the next accept. `dec_out` is sampled only in DECODE.
- Reset:
  - Next state is IDLE; any in-flight line is dropped without incrementing `line_cnt`.
  - Reset values: `in_ready`=1 after release, `out_valid`=0, `out_last`=0, `out_keep`=0, `out_data`=0, `len_err`=0, `busy`=0, `line_cnt`=0, `dec_in`=0.

## Timing
- Accept at edge N. DECODE is cycle N+1. First `out_valid` is in cycle N+2.
- Line occupancy: beats+2 cycles minimum (27 cycles for a full line), plus stall cycles.
- Beats per line: 1 (len 1..4) to 25 (len 97..100).
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_keep` and `out_last` hold stable. `out_valid` never drops without a handshake, except on reset.
- `line_cnt` updates on the edge of the last-beat handshake and is visible in the same cycle `in_ready` returns to 1.
- `len_err` is registered: high in the DECODE cycle only.
- Wrap: `line_cnt` goes 2^CNT_W-1 -> 0 with no flag.

## Test plan
- Full line, len=100, `out_ready`=1 -> `out_valid` first seen 2 cycles after accept. 25 beats, all keep 4'b1111, `out_last` only on beat 24. Data matches the decompressor model; `line_cnt` 0->1.
- len=5 -> 2 beats; beat 0 keep 4'b1111, beat 1 keep 4'b0001 with `out_last`=1. len=8 -> 2 beats, last keep 4'b1111.
- Backpressure: toggle `out_ready` pseudo-randomly on a full line -> beat outputs stable across every stall; exactly 25 handshakes; `in_ready`=0 throughout STREAM.
- in_len=0, then in_len=127 -> each line streams 25 beats, `len_err` high for exactly one cycle (the DECODE cycle) per line.
- Assert `rst_n`=0 for one cycle at beat 10 of a full line -> next cycle `out_valid`=0, `busy`=0, `in_ready`=1, `line_cnt` unchanged from before the line; the next line streams normally.
- Preload: stream 65535 lines with len=1 -> `line_cnt`=0xFFFF; one more line -> `line_cnt`=0x0000.

Source files
------------

// File: rtl/gene_line_stream_ctrl.sv
// Line sequencer around the combinational 100-base decompressor: accepts one packed line,
// holds it for the decompressor, captures the characters and streams them as 32-bit beats.
module gene_line_stream_ctrl #(
  parameter int unsigned LINE_BASES = 100,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*LINE_BASES-1:0] in_data,
  input  logic [6:0]              in_len,
  output logic [2*LINE_BASES-1:0] dec_in,
  input  logic [8*LINE_BASES-1:0] dec_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic [3:0]              out_keep,
  output logic                    out_last,
  output logic                    len_err,
  output logic                    busy,
  output logic [CNT_W-1:0]        line_cnt
);

  typedef enum logic [1:0] {StIdle, StDecode, StStream} state_e;

  state_e                    state_q, state_d;
  logic [2*LINE_BASES-1:0]   line_q, line_d;
  logic [6:0]                len_q, len_d;
  logic [8*LINE_BASES-1:0]   out_buf_q, out_buf_d;
  logic [4:0]                beat_q, beat_d;
  logic [4:0]                beats_q, beats_d;
  logic [CNT_W-1:0]          line_cnt_q, line_cnt_d;
  logic                      len_err_q, len_err_d;

  logic                      len_bad;
  logic [6:0]                eff_len;
  logic                      is_last;

  // Out-of-range lengths are treated as a full line rather than rejected.
  assign len_bad = (in_len == 7'd0) || (in_len > 7'(LINE_BASES));
  assign eff_len = len_bad ? 7'(LINE_BASES) : in_len;
  assign is_last = (beat_q == beats_q - 5'd1);

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    len_d      = len_q;
    out_buf_d  = out_buf_q;
    beat_d     = beat_q;
    beats_d    = beats_q;
    line_cnt_d = line_cnt_q;
    len_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          line_d    = in_data;
          len_d     = eff_len;
          len_err_d = len_bad;
          state_d   = StDecode;
        end
      end
      StDecode: begin
        out_buf_d = dec_out;
        beat_d    = 5'd0;
        beats_d   = 5'((len_q + 7'd3) >> 2);
        state_d   = StStream;
      end
      StStream: begin
        if (out_ready) begin
          if (is_last) begin
            line_cnt_d = line_cnt_q + CNT_W'(1);
            state_d    = StIdle;
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      line_q     <= '0;
      len_q      <= '0;
      out_buf_q  <= '0;
      beat_q     <= '0;
      beats_q    <= '0;
      line_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      len_q      <= len_d;
      out_buf_q  <= out_buf_d;
      beat_q     <= beat_d;
      beats_q    <= beats_d;
      line_cnt_q <= line_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StStream);
  assign out_last  = out_valid && is_last;
  assign out_data  = out_valid ? out_buf_q[{beat_q, 5'b0} +: 32] : 32'd0;
  assign dec_in    = line_q;
  assign len_err   = len_err_q;
  assign line_cnt  = line_cnt_q;

  always_comb begin
    out_keep = 4'b0000;
    if (out_valid) begin
      if (!is_last) begin
        out_keep = 4'b1111;
      end else begin
        unique case (len_q[1:0])
          2'd0:    out_keep = 4'b1111;
          2'd1:    out_keep = 4'b0001;
          2'd2:    out_keep = 4'b0011;
          default: out_keep = 4'b0111;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gene_line_stream_ctrl.sv
// Randomised bench for gene_line_stream_ctrl: a queue-of-beats reference model checked every
// cycle, plus literal expectations on latency, beat counts, keep masks and counter wrap.
module tb_gene_line_stream_ctrl;

  localparam int unsigned CntW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [199:0]    in_data;
  logic [6:0]      in_len;
  logic [199:0]    dec_in;
  logic [799:0]    dec_out;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic [3:0]      out_keep;
  logic            out_last;
  logic            len_err;
  logic            busy;
  logic [CntW-1:0] line_cnt;

  gene_line_stream_ctrl #(.CNT_W(CntW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .dec_in    (dec_in),
    .dec_out   (dec_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .len_err   (len_err),
    .busy      (busy),
    .line_cnt  (line_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] base_char(input logic [1:0] c);
    case (c)
      2'd0:    return 8'h41;
      2'd1:    return 8'h43;
      2'd2:    return 8'h47;
      default: return 8'h54;
    endcase
  endfunction

  // Stand-in for the combinational decompressor.
  always_comb begin
    for (int j = 0; j < 100; j++) dec_out[8*j +: 8] = base_char(dec_in[2*j +: 2]);
  end

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [199:0] act,
                                input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t         m_q[$];
  int            m_delay = 0;
  logic [CntW-1:0] m_cnt = '0;
  logic          m_lerr = 1'b0;
  logic [199:0]  m_line = '0;
  bit            chk_en = 1'b0;

  function automatic void model_shape(input logic [6:0] len, output int eff, output int nb,
                                      output logic [3:0] lk);
    eff = (len >= 7'd1 && len <= 7'd100) ? int'(len) : 100;
    nb  = (eff + 3) / 4;
    lk  = (eff % 4 == 0) ? 4'hF : 4'((1 << (eff % 4)) - 1);
  endfunction

  function automatic void model_load(input logic [199:0] data, input logic [6:0] len);
    int eff, nb;
    logic [3:0] lk;
    beat_t b;
    model_shape(len, eff, nb, lk);
    m_q.delete();
    for (int bi = 0; bi < nb; bi++) begin
      for (int k = 0; k < 4; k++) b.data[8*k +: 8] = base_char(data[2*(4*bi+k) +: 2]);
      b.last = (bi == nb - 1);
      b.keep = b.last ? lk : 4'hF;
      m_q.push_back(b);
    end
  endfunction

  // ---------------- DUT statistics (written only here) ----------------
  int          hs_tot = 0;
  int          lerr_tot = 0;
  int          hs_at_acc = 0;
  int          dut_lat = -1;
  int          lat_cnt = 0;
  bit          lat_trk = 1'b0;
  logic [3:0]  last_keep = '0;
  logic [31:0] first_data = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit    exp_busy, exp_valid;
      beat_t b;
      exp_busy  = (m_q.size() != 0);
      exp_valid = exp_busy && (m_delay == 0);
      check("busy", busy, exp_busy);
      check("in_ready", in_ready, !exp_busy);
      check("out_valid", out_valid, exp_valid);
      check("len_err", len_err, m_lerr);
      check("line_cnt", line_cnt, m_cnt);
      check("dec_in", dec_in, m_line);
      if (exp_valid) begin
        check("out_data", out_data, m_q[0].data);
        check("out_keep", out_keep, m_q[0].keep);
        check("out_last", out_last, m_q[0].last);
      end

      if (len_err) lerr_tot++;
      if (!rst_n) begin
        lat_trk = 1'b0;
      end else if (in_valid && in_ready) begin
        lat_cnt   = 0;
        lat_trk   = 1'b1;
        hs_at_acc = hs_tot;
      end else if (lat_trk) begin
        lat_cnt++;
        if (out_valid) begin
          dut_lat = lat_cnt;
          lat_trk = 1'b0;
        end
      end
      if (rst_n && out_valid && out_ready) begin
        if (hs_tot == hs_at_acc) first_data = out_data;
        hs_tot++;
        if (out_last) last_keep = out_keep;
      end

      // Advance the model across the coming edge.
      if (!rst_n) begin
        m_q.delete();
        m_delay = 0;
        m_cnt   = '0;
        m_lerr  = 1'b0;
        m_line  = '0;
      end else begin
        m_lerr = 1'b0;
        if (exp_busy) begin
          if (m_delay > 0) begin
            m_delay--;
          end else if (out_ready) begin
            b = m_q.pop_front();
            if (b.last) m_cnt = m_cnt + 1'b1;
          end
        end else if (in_valid) begin
          model_load(in_data, in_len);
          m_line  = in_data;
          m_delay = 1;
          m_lerr  = !(in_len >= 7'd1 && in_len <= 7'd100);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [199:0] rand_line();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[32*i +: 32] = $urandom;
    return t[199:0];
  endfunction

  int hs0, lerr0;

  // mode 0: out_ready held high; mode 1: random backpressure. rst_at >= 0 resets mid-line.
  task automatic run_line(input logic [6:0] len, input logic [199:0] data, input int mode,
                          input int rst_at);
    bit done;
    hs0      = hs_tot;
    lerr0    = lerr_tot;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    in_len   = len;
    out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    cyc();
    in_valid = 1'b0;
    in_data  = rand_line();
    in_len   = 7'($urandom_range(0, 127));
    for (int n = 0; n < 400; n++) begin
      if (rst_at >= 0 && hs_tot - hs0 == rst_at) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        done  = 1'b1;
        break;
      end
      out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc();
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check("line_done", done, 1'b1);
  endtask

  int         p_eff, p_nb;
  logic [3:0] p_lk;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    out_ready = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;

    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_keep", out_keep, 4'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_len_err", len_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_line_cnt", line_cnt, 8'h00);
    check("rst_dec_in", dec_in, 200'h0);

    // Model pins.
    model_shape(7'd5, p_eff, p_nb, p_lk);
    check("pin5_beats", 200'(p_nb), 200'd2);
    check("pin5_keep", p_lk, 4'b0001);
    model_shape(7'd8, p_eff, p_nb, p_lk);
    check("pin8_keep", p_lk, 4'b1111);
    model_shape(7'd0, p_eff, p_nb, p_lk);
    check("pin0_beats", 200'(p_nb), 200'd25);
    model_shape(7'd99, p_eff, p_nb, p_lk);
    check("pin99_keep", p_lk, 4'b0111);

    // Reset at beat 10 of a full line.
    run_line(7'd100, rand_line(), 0, 10);
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_in_ready", in_ready, 1'b1);
    check("mrst_line_cnt", line_cnt, 8'h00);

    run_line(7'd100, rand_line(), 0, -1);
    check("full_latency", 200'(dut_lat), 200'd2);
    check("full_beats", 200'(hs_tot - hs0), 200'd25);
    check("full_last_keep", last_keep, 4'hF);
    check("full_line_cnt", line_cnt, 8'h01);

    run_line(7'd5, rand_line(), 0, -1);
    check("len5_beats", 200'(hs_tot - hs0), 200'd2);
    check("len5_last_keep", last_keep, 4'b0001);
    run_line(7'd8, rand_line(), 0, -1);
    check("len8_beats", 200'(hs_tot - hs0), 200'd2);
    check("len8_last_keep", last_keep, 4'b1111);
    run_line(7'd3, {100{2'b11}}, 0, -1);
    check("len3_data", first_data, 32'h54545454);
    check("len3_last_keep", last_keep, 4'b0111);

    run_line(7'd100, rand_line(), 1, -1);
    check("bp_beats", 200'(hs_tot - hs0), 200'd25);

    run_line(7'd0, rand_line(), 0, -1);
    check("len0_beats", 200'(hs_tot - hs0), 200'd25);
    check("len0_err_cycles", 200'(lerr_tot - lerr0), 200'd1);
    run_line(7'd127, rand_line(), 1, -1);
    check("len127_beats", 200'(hs_tot - hs0), 200'd25);
    check("len127_err_cycles", 200'(lerr_tot - lerr0), 200'd1);

    for (int i = 0; i < 40; i++) run_line(7'($urandom_range(0, 127)), rand_line(), 1, -1);

    for (int i = 0; i < 300; i++) begin
      if (line_cnt == 8'hFF) break;
      run_line(7'd1, rand_line(), 0, -1);
    end
    check("wrap_top", line_cnt, 8'hFF);
    run_line(7'd1, rand_line(), 0, -1);
    check("wrap_zero", line_cnt, 8'h00);
    run_line(7'd100, rand_line(), 1, -1);
    check("post_wrap_beats", 200'(hs_tot - hs0), 200'd25);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
